// File: rtl/inst_replay_pkg.sv
// Shared types and constants for the instruction replay checker.
// The state enum, probe channel indices and table-entry width helper live here.
package inst_replay_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int PROBE_WRTREG = 0;
  localparam int PROBE_ALU    = 1;
  localparam int PROBE_REG2   = 2;
  localparam int PROBE_PC     = 3;

  // Entry layout, MSB to LSB: {inst, exp[NUM_PROBES-1..0], mask}
  function automatic int entry_width(input int inst_bits, input int dbits, input int num_probes);
    return inst_bits + num_probes * dbits + num_probes;
  endfunction

endpackage

// File: rtl/inst_replay_checker_table.sv
// Replay table: DEPTH x entry register array with one write port and an asynchronous read.
// Contents are deliberately not reset so a table survives a run abort.
module replay_table #(
  parameter int DEPTH    = 16,
  parameter int IDX_BITS = 4,
  parameter int EW       = 164
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [EW-1:0]       wr_data_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [EW-1:0]       rd_data_o
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (int'(wr_idx_i) < DEPTH)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (int'(rd_idx_i) < DEPTH) begin
      rd_data_o = mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/inst_replay_checker.sv
// Instruction replay engine: steps the CPU once per table entry and compares masked
// datapath probes against the expected values, reporting pass/fail and first failure.
module inst_replay_checker
  import inst_replay_pkg::*;
#(
  parameter int DBITS          = 32,
  parameter int INST_BIT_WIDTH = 32,
  parameter int DEPTH          = 16,
  parameter int IDX_BITS       = 4,
  parameter int NUM_PROBES     = 4,
  parameter int CNT_BITS       = 8,
  parameter int STOP_ON_FAIL   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [IDX_BITS:0]              run_len,
  input  logic                           load_we,
  input  logic [IDX_BITS-1:0]            load_idx,
  input  logic [INST_BIT_WIDTH-1:0]      load_inst,
  input  logic [NUM_PROBES*DBITS-1:0]    load_exp,
  input  logic [NUM_PROBES-1:0]          load_mask,
  input  logic [NUM_PROBES*DBITS-1:0]    probe_in,
  output logic [INST_BIT_WIDTH-1:0]      inst_word,
  output logic                           cpu_step,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [IDX_BITS-1:0]            fail_idx,
  output logic [1:0]                     fail_probe,
  output logic [CNT_BITS-1:0]            err_count,
  output logic [2:0]                     dbg_state
);

  localparam int EW       = entry_width(INST_BIT_WIDTH, DBITS, NUM_PROBES);
  localparam int EXP_LSB  = NUM_PROBES;
  localparam int INST_LSB = NUM_PROBES + NUM_PROBES * DBITS;
  localparam logic [IDX_BITS:0] DEPTH_L = (IDX_BITS+1)'(DEPTH);

  state_e                  state_q;
  logic [IDX_BITS-1:0]     idx_q;
  logic [IDX_BITS:0]       len_q;
  logic [EW-1:0]           entry_q;
  logic                    cpu_step_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [IDX_BITS-1:0]     fail_idx_q;
  logic [1:0]              fail_probe_q;
  logic [CNT_BITS-1:0]     err_q;

  logic                    tbl_we;
  logic [IDX_BITS-1:0]     rd_idx_d;
  logic [EW-1:0]           rd_data;
  logic [IDX_BITS:0]       len_d;
  logic [CNT_BITS-1:0]     err_d;
  logic [NUM_PROBES-1:0]   miss;
  logic [1:0]              low_probe;
  logic                    any_miss;
  logic                    last_entry;
  logic                    first_fail;

  assign tbl_we = load_we && ((state_q == IDLE) || (state_q == DONE));

  // Addressed by the index the next DRIVE will use, so the entry is latched on entry to DRIVE.
  assign rd_idx_d = (state_q == CHECK) ? idx_q + IDX_BITS'(1) : '0;

  replay_table #(
    .DEPTH    (DEPTH),
    .IDX_BITS (IDX_BITS),
    .EW       (EW)
  ) u_table (
    .clk       (clk),
    .we_i      (tbl_we),
    .wr_idx_i  (load_idx),
    .wr_data_i ({load_inst, load_exp, load_mask}),
    .rd_idx_i  (rd_idx_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    miss      = '0;
    low_probe = '0;
    for (int p = 0; p < NUM_PROBES; p++) begin
      miss[p] = entry_q[p] &&
                (probe_in[p*DBITS +: DBITS] != entry_q[EXP_LSB + p*DBITS +: DBITS]);
    end
    for (int p = NUM_PROBES - 1; p >= 0; p--) begin
      if (miss[p]) low_probe = 2'(p);
    end
  end

  assign any_miss   = |miss;
  assign len_d      = (run_len > DEPTH_L) ? DEPTH_L : run_len;
  assign last_entry = ({1'b0, idx_q} == (len_q - (IDX_BITS+1)'(1)));
  // Saturation keeps err_q nonzero once set, so zero also means "no failure latched yet".
  assign first_fail = (err_q == '0);
  assign err_d      = !any_miss ? err_q : ((err_q == '1) ? err_q : err_q + CNT_BITS'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      entry_q      <= '0;
      cpu_step_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_idx_q   <= '0;
      fail_probe_q <= '0;
      err_q        <= '0;
    end else begin
      cpu_step_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            err_q        <= '0;
            fail_idx_q   <= '0;
            fail_probe_q <= '0;
            if (run_len == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q    <= DRIVE;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              pass_q     <= 1'b0;
              idx_q      <= '0;
              len_q      <= len_d;
              entry_q    <= rd_data;
              cpu_step_q <= 1'b1;
            end
          end
        end
        DRIVE:  state_q <= SAMPLE;
        SAMPLE: state_q <= CHECK;
        CHECK: begin
          err_q <= err_d;
          if (any_miss && first_fail) begin
            fail_idx_q   <= idx_q;
            fail_probe_q <= low_probe;
          end
          if ((any_miss && (STOP_ON_FAIL != 0)) || last_entry) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q    <= DRIVE;
            idx_q      <= idx_q + IDX_BITS'(1);
            entry_q    <= rd_data;
            cpu_step_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_word  = entry_q[INST_LSB +: INST_BIT_WIDTH];
  assign cpu_step   = cpu_step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_idx   = fail_idx_q;
  assign fail_probe = fail_probe_q;
  assign err_count  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_replay_checker.sv
// Bench for inst_replay_checker: two instances (halt-on-fail, and run-to-end with a 2-bit
// error counter) share stimulus; a run-level reference model supplies expected results.
module tb_inst_replay_checker;

  localparam int DB = 32;
  localparam int NP = 4;

  typedef struct {
    int steps;
    int done_m;
    int err;
    bit pass;
    int fidx;
    int fprobe;
  } res_t;

  typedef struct {
    int          len;
    logic [15:0] bad;
    int          bad_p;
    res_t        ea;
    res_t        eb;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [4:0]         run_len = '0;
  logic               load_we = 1'b0;
  logic [3:0]         load_idx = '0;
  logic [31:0]        load_inst = '0;
  logic [NP*DB-1:0]   load_exp = '0;
  logic [NP-1:0]      load_mask = '0;
  logic [NP*DB-1:0]   probe_in = '0;

  logic [31:0] a_inst, b_inst;
  logic        a_step, b_step, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
  logic [3:0]  a_fidx, b_fidx;
  logic [1:0]  a_fprobe, b_fprobe;
  logic [7:0]  a_err;
  logic [1:0]  b_err;
  logic [2:0]  a_state, b_state;

  logic [31:0] tb_inst [16];
  logic [31:0] tb_exp  [16][NP];
  logic [3:0]  tb_mask [16];
  logic [31:0] act     [16][NP];

  int checks = 0;
  int failures = 0;
  int obs_sa, obs_sb, obs_ma, obs_mb;
  vec_t vecs [7];

  always #5 clk = ~clk;

  inst_replay_checker #(.CNT_BITS(8), .STOP_ON_FAIL(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len),
    .load_we(load_we), .load_idx(load_idx), .load_inst(load_inst),
    .load_exp(load_exp), .load_mask(load_mask), .probe_in(probe_in),
    .inst_word(a_inst), .cpu_step(a_step), .busy(a_busy), .done(a_done),
    .pass(a_pass), .fail_idx(a_fidx), .fail_probe(a_fprobe),
    .err_count(a_err), .dbg_state(a_state)
  );

  inst_replay_checker #(.CNT_BITS(2), .STOP_ON_FAIL(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len),
    .load_we(load_we), .load_idx(load_idx), .load_inst(load_inst),
    .load_exp(load_exp), .load_mask(load_mask), .probe_in(probe_in),
    .inst_word(b_inst), .cpu_step(b_step), .busy(b_busy), .done(b_done),
    .pass(b_pass), .fail_idx(b_fidx), .fail_probe(b_fprobe),
    .err_count(b_err), .dbg_state(b_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Run-level model: walk the entries in order, a mismatch is any masked probe differing.
  function automatic res_t model(input int len, input bit stop, input int sat);
    res_t r;
    int n, errs;
    r = '{steps: 0, done_m: 1, err: 0, pass: 1'b1, fidx: 0, fprobe: 0};
    n = (len > 16) ? 16 : len;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      int low;
      low = -1;
      r.steps++;
      for (int p = NP - 1; p >= 0; p--)
        if (tb_mask[i][p] && (act[i][p] != tb_exp[i][p])) low = p;
      if (low >= 0) begin
        if (errs == 0) begin
          r.fidx = i;
          r.fprobe = low;
        end
        errs++;
        if (stop) break;
      end
    end
    r.err = (errs > sat) ? sat : errs;
    r.pass = (errs == 0);
    r.done_m = (len == 0) ? 1 : 1 + 3 * r.steps;
    return r;
  endfunction

  task automatic write_entry(input int i);
    load_we = 1'b1;
    load_idx = i[3:0];
    load_inst = tb_inst[i];
    for (int p = 0; p < NP; p++) load_exp[p*DB +: DB] = tb_exp[i][p];
    load_mask = tb_mask[i];
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic write_all();
    for (int i = 0; i < 16; i++) write_entry(i);
  endtask

  // Called at a negedge. The bench plays the CPU: after each step it presents that entry's probes.
  task automatic run(input int len, input bit poke, input int abort_at);
    int sa, sb, ma, mb;
    sa = 0; sb = 0; ma = -1; mb = -1;
    start = 1'b1;
    run_len = len[4:0];
    for (int m = 1; m <= 80; m++) begin
      @(negedge clk);
      start = 1'b0;
      load_we = 1'b0;
      if (m == 1) chk("busy_after_start", {31'b0, a_busy}, {31'b0, (len > 0)});
      if (a_step) begin
        sa++;
        if (sa <= 16) chk("inst_word_a", a_inst, tb_inst[sa-1]);
      end
      if (b_step) begin
        sb++;
        if (sb <= 16) begin
          chk("inst_word_b", b_inst, tb_inst[sb-1]);
          for (int p = 0; p < NP; p++) probe_in[p*DB +: DB] = act[sb-1][p];
        end
      end
      if (poke && m == 2) begin
        start = 1'b1;
        run_len = 5'd0;
        load_we = 1'b1;
        load_idx = 4'd0;
        load_inst = 32'hdead_beef;
      end
      if (abort_at == m) begin
        reset = 1'b0;
        @(negedge clk);
        chk("abort_inst", a_inst, 32'h0);
        chk("abort_step", {31'b0, a_step | b_step}, 32'h0);
        chk("abort_busy", {31'b0, a_busy | b_busy}, 32'h0);
        chk("abort_done", {31'b0, a_done | b_done}, 32'h0);
        chk("abort_pass", {31'b0, a_pass | b_pass}, 32'h0);
        chk("abort_err", {24'b0, a_err}, 32'h0);
        chk("abort_fidx", {28'b0, a_fidx | b_fidx}, 32'h0);
        chk("abort_state", {29'b0, a_state}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_step", {31'b0, a_step | b_step}, 32'h0);
        return;
      end
      if (ma < 0 && a_done) ma = m;
      if (mb < 0 && b_done) mb = m;
      if (ma >= 0 && mb >= 0) break;
    end
    start = 1'b0;
    load_we = 1'b0;
    obs_sa = sa; obs_sb = sb; obs_ma = ma; obs_mb = mb;
  endtask

  task automatic check_run(input res_t ea, input res_t eb);
    chk("steps_a", obs_sa, ea.steps);
    chk("done_cycle_a", obs_ma, ea.done_m);
    chk("err_count_a", {24'b0, a_err}, ea.err);
    chk("pass_a", {31'b0, a_pass}, {31'b0, ea.pass});
    chk("busy_end_a", {31'b0, a_busy}, 32'h0);
    if (ea.err != 0) begin
      chk("fail_idx_a", {28'b0, a_fidx}, ea.fidx);
      chk("fail_probe_a", {30'b0, a_fprobe}, ea.fprobe);
    end
    chk("steps_b", obs_sb, eb.steps);
    chk("done_cycle_b", obs_mb, eb.done_m);
    chk("err_count_b", {30'b0, b_err}, eb.err);
    chk("pass_b", {31'b0, b_pass}, {31'b0, eb.pass});
    chk("busy_end_b", {31'b0, b_busy}, 32'h0);
    if (eb.err != 0) begin
      chk("fail_idx_b", {28'b0, b_fidx}, eb.fidx);
      chk("fail_probe_b", {30'b0, b_fprobe}, eb.fprobe);
    end
  endtask

  task automatic run_model(input int len);
    res_t ea, eb;
    ea = model(len, 1'b1, 255);
    eb = model(len, 1'b0, 3);
    run(len, 1'b0, 0);
    check_run(ea, eb);
  endtask

  initial begin
    vecs[0] = '{2,  16'h0000, 0, '{2, 7, 0, 1, 0, 0},  '{2, 7, 0, 1, 0, 0}};
    vecs[1] = '{0,  16'h0000, 0, '{0, 1, 0, 1, 0, 0},  '{0, 1, 0, 1, 0, 0}};
    vecs[2] = '{31, 16'h0000, 0, '{16, 49, 0, 1, 0, 0}, '{16, 49, 0, 1, 0, 0}};
    vecs[3] = '{4,  16'h0001, 1, '{1, 4, 1, 0, 0, 1},  '{4, 13, 1, 0, 0, 1}};
    vecs[4] = '{5,  16'h000A, 2, '{2, 7, 1, 0, 1, 2},  '{5, 16, 2, 0, 1, 2}};
    vecs[5] = '{16, 16'h0555, 3, '{1, 4, 1, 0, 0, 3},  '{16, 49, 3, 0, 0, 3}};
    vecs[6] = '{1,  16'h0020, 0, '{1, 4, 0, 1, 0, 0},  '{1, 4, 0, 1, 0, 0}};

    repeat (3) @(negedge clk);
    chk("reset_inst", a_inst, 32'h0);
    chk("reset_step", {31'b0, a_step | b_step}, 32'h0);
    chk("reset_busy", {31'b0, a_busy | b_busy}, 32'h0);
    chk("reset_done", {31'b0, a_done | b_done}, 32'h0);
    chk("reset_pass", {31'b0, a_pass | b_pass}, 32'h0);
    chk("reset_err", {24'b0, a_err}, 32'h0);
    chk("reset_fail", {26'b0, a_fidx, a_fprobe}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven vectors: all probes masked, chosen entries corrupted on one probe.
    for (int i = 0; i < 16; i++) begin
      tb_inst[i] = $urandom;
      tb_mask[i] = 4'hF;
      for (int p = 0; p < NP; p++) tb_exp[i][p] = $urandom;
    end
    write_all();
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++)
        for (int p = 0; p < NP; p++)
          act[i][p] = tb_exp[i][p] ^ ((vecs[v].bad[i] && p == vecs[v].bad_p) ? 32'h1 : 32'h0);
      run(vecs[v].len, (v == 4), 0);
      check_run(vecs[v].ea, vecs[v].eb);
    end

    // Two passing single-probe entries.
    tb_inst[0] = 32'h804d0037; tb_mask[0] = 4'b0001;
    tb_inst[1] = 32'h805d00e1; tb_mask[1] = 4'b0001;
    tb_exp[0][0] = 32'h37; tb_exp[1][0] = 32'hE1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < NP; p++) act[i][p] = $urandom;
      act[i][0] = tb_exp[i][0];
      write_entry(i);
    end
    run_model(2);
    chk("two_entry_done_cycle", obs_ma, 7);

    // ALU mismatch on entry 0; entry 2 unmasked with garbage probes.
    tb_inst[0] = 32'h802d0400; tb_mask[0] = 4'b0010; tb_exp[0][1] = 32'h400;
    for (int p = 0; p < NP; p++) act[0][p] = tb_exp[0][p];
    act[0][1] = 32'h404;
    tb_mask[2] = 4'b0000;
    for (int p = 0; p < NP; p++) begin
      act[1][p] = tb_exp[1][p];
      act[2][p] = ~tb_exp[2][p];
      act[3][p] = tb_exp[3][p];
    end
    write_entry(0);
    write_entry(2);
    run_model(4);
    chk("alu_fail_steps_a", obs_sa, 1);

    // Reset during SAMPLE of entry 2, then a normal single-entry run.
    for (int p = 0; p < NP; p++) act[0][p] = tb_exp[0][p];
    run(5, 1'b0, 8);
    run_model(1);

    // Randomized runs against the model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) begin
        tb_inst[i] = $urandom;
        tb_mask[i] = 4'($urandom_range(0, 15));
        for (int p = 0; p < NP; p++) begin
          tb_exp[i][p] = $urandom;
          act[i][p] = ($urandom_range(0, 7) == 0) ? $urandom : tb_exp[i][p];
        end
      end
      write_all();
      run_model($urandom_range(0, 31));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
